// File: rtl/param_cfg_pkg.sv
// Shared types for the parameter bank scheduler.
package param_cfg_pkg;

    // Scheduler phases: arbitrate, touch the bank, deliver the response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } param_cfg_state_e;

endpackage

// File: rtl/param_cfg_sched_rr_arbiter.sv
// Round-robin winner search; the parent owns and updates the pointer.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Scan starting one past the last winner so every requester gets a turn.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                winner      = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_cfg_sched.sv
// Arbitrated parameter register bank with write lock and flat parameter export.
module param_cfg_sched
    import param_cfg_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int NUM_PARAMS = 8,
    parameter  int DATA_W     = 32,
    localparam int ADDR_W     = $clog2(NUM_PARAMS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    input  logic                         lock_i,
    output logic [NUM_PARAMS*DATA_W-1:0] param_q,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } param_cfg_cmd_t;

    param_cfg_state_e                  state;
    param_cfg_cmd_t                    cmd;
    logic [IDX_W-1:0]                  last_grant;
    logic [IDX_W-1:0]                  owner;
    logic [NUM_PARAMS-1:0][DATA_W-1:0] params;
    logic [NUM_REQ-1:0][ADDR_W-1:0]    addr_v;
    logic [NUM_REQ-1:0][DATA_W-1:0]    wdata_v;
    logic [NUM_REQ-1:0]                grant;
    logic [IDX_W-1:0]                  winner;
    logic                              any;
    logic                              acc_err;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner),
        .any        (any)
    );

    // Only offer a grant while the bank is free.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);
    assign param_q   = params;

    // Out-of-range index, or a write while locked; lock is looked at in ACCESS only.
    assign acc_err = (int'(cmd.addr) >= NUM_PARAMS) || (cmd.we && lock_i);

    // Scheduler FSM: latch the winner, access the bank, strobe the owner's response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd        <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            params     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        cmd.we     <= req_we[winner];
                        cmd.addr   <= addr_v[winner];
                        cmd.wdata  <= wdata_v[winner];
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!acc_err && cmd.we)
                        params[cmd.addr] <= cmd.wdata;
                    rsp_rdata <= (!acc_err && !cmd.we) ? params[cmd.addr] : '0;
                    rsp_err   <= acc_err;
                    rsp_valid <= NUM_REQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_cfg_sched.sv
// Bench for param_cfg_sched: transaction-level reference model plus directed and random traffic.
module tb_param_cfg_sched;

    localparam int NR = 4, NP = 8, DW = 32, AW = 3;

    logic                  clk = 1'b0, rst_n = 1'b1, lock_i = 1'b0;
    logic [NR-1:0]         req_valid = '0, req_we = '0, req_ready, rsp_valid;
    logic [NR-1:0][AW-1:0] req_addr = '0;
    logic [NR-1:0][DW-1:0] req_wdata = '0;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_err, busy;
    logic [NP-1:0][DW-1:0] param_q;

    // second instance: 2 requesters, 6 entries (addresses 6 and 7 are out of range)
    logic [1:0]        v6 = '0, we6 = '0, rdy6, rv6;
    logic [1:0][2:0]   a6 = '0;
    logic [1:0][31:0]  w6 = '0;
    logic [31:0]       rd6;
    logic              er6, busy6, lock6 = 1'b0;
    logic [5:0][31:0]  pq6;

    param_cfg_sched #(.NUM_REQ(NR), .NUM_PARAMS(NP), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lock_i(lock_i), .param_q(param_q), .busy(busy)
    );

    param_cfg_sched #(.NUM_REQ(2), .NUM_PARAMS(6), .DATA_W(32)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(v6), .req_ready(rdy6),
        .req_we(we6), .req_addr(a6), .req_wdata(w6),
        .rsp_valid(rv6), .rsp_rdata(rd6), .rsp_err(er6),
        .lock_i(lock6), .param_q(pq6), .busy(busy6)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    endtask

    // ---------------- reference model ----------------
    // A granted request occupies the bank for three cycles: grant, access, response.
    int                    phase, last, m_owner, m_addr, pick;
    logic                  m_we, m_err, e_err;
    logic [DW-1:0]         m_wdata, e_rdata;
    logic [DW-1:0]         mp [NP];
    logic [NR-1:0]         e_ready, e_rsp;
    logic [NP-1:0][DW-1:0] mpq;

    initial begin
        phase = 0; last = NR - 1;
        for (int i = 0; i < NP; i++) mp[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0; last = NR - 1;
                for (int i = 0; i < NP; i++) mp[i] = '0;
            end
            pick = -1; e_ready = '0;
            if (phase == 0)
                for (int k = 1; k <= NR; k++)
                    if (pick < 0 && req_valid[(last + k) % NR]) pick = (last + k) % NR;
            if (pick >= 0) e_ready[pick] = 1'b1;
            e_rsp = '0;
            if (phase == 2) e_rsp[m_owner] = 1'b1;
            for (int i = 0; i < NP; i++) mpq[i] = mp[i];
            chk("m_ready", req_ready, e_ready);
            chk("m_busy", busy, phase != 0);
            chk("m_rsp_valid", rsp_valid, e_rsp);
            if (phase == 2) begin
                chk("m_rsp_rdata", rsp_rdata, e_rdata);
                chk("m_rsp_err", rsp_err, e_err);
            end
            chk("m_param_q", param_q, mpq);
            if (rst_n) begin
                if (phase == 0) begin
                    if (pick >= 0) begin
                        m_owner = pick; m_we = req_we[pick];
                        m_addr = int'(req_addr[pick]); m_wdata = req_wdata[pick];
                        last = pick; phase = 1;
                    end
                end else if (phase == 1) begin
                    m_err = (m_addr >= NP) || (m_we && lock_i);
                    if (!m_err && m_we) mp[m_addr] = m_wdata;
                    e_rdata = (!m_err && !m_we) ? mp[m_addr] : '0;
                    e_err = m_err; phase = 2;
                end else phase = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    logic [255:0] pq_acc, pq_rsp;
    int           lat;

    task automatic txn(input int who, input logic we, input int addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        int hs_c = 0;
        bit ok = 0;
        rd = '0; er = 1'b0;
        req_we[who] = we; req_addr[who] = AW'(addr); req_wdata[who] = wd; req_valid[who] = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[who]) begin ok = 1; hs_c = cyc; end
        end
        chk("txn_handshake", ok, 1'b1);
        @(posedge clk); #1; req_valid[who] = 1'b0;
        if (!ok) return;
        @(negedge clk); pq_acc = param_q; ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid[who]) begin
                ok = 1; rd = rsp_rdata; er = rsp_err; lat = cyc - hs_c; pq_rsp = param_q;
            end
        end
        chk("txn_response", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic txn6(input int who, input logic we, input int addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        bit ok = 0;
        rd = '0; er = 1'b0;
        we6[who] = we; a6[who] = 3'(addr); w6[who] = wd; v6[who] = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = rdy6[who]; end
        chk("np6_handshake", ok, 1'b1);
        @(posedge clk); #1; v6[who] = 1'b0;
        if (!ok) return;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rv6[who]) begin ok = 1; rd = rd6; er = er6; end
        end
        chk("np6_response", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; lock_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0]   rd;
    logic          er;
    logic [NR-1:0] hs, waiting;
    int            ng, gidx [5], gcyc [5];
    int            exp_order [5] = '{0, 1, 2, 3, 0};
    bit            got;
    logic [191:0]  e6;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_param_q", param_q, 256'h0);
        @(posedge clk); #1;

        // write, then read back, from different requesters
        txn(2, 1'b1, 3, 32'hDEADBEEF, rd, er);
        chk("wr_err", er, 1'b0);
        chk("wr_rdata", rd, 32'h0);
        chk("wr_latency", lat, 2);
        chk("wr_old_at_access", pq_acc[3*32 +: 32], 32'h0);
        chk("wr_new_at_resp", pq_rsp[3*32 +: 32], 32'hDEADBEEF);
        txn(0, 1'b0, 3, 32'h0, rd, er);
        chk("rd3_data", rd, 32'hDEADBEEF);
        chk("rd3_err", er, 1'b0);
        txn(1, 1'b0, 5, 32'h0, rd, er);
        chk("rd5_data", rd, 32'h0);

        // lock
        lock_i = 1'b1;
        txn(1, 1'b1, 0, 32'h55, rd, er);
        chk("lock_err", er, 1'b1);
        chk("lock_entry0", pq_rsp[31:0], 32'h0);
        lock_i = 1'b0;
        txn(1, 1'b1, 0, 32'h55, rd, er);
        chk("unlock_err", er, 1'b0);
        chk("unlock_entry0", pq_rsp[31:0], 32'h55);

        // all requesters continuously valid after reset
        do_reset();
        req_we = '0; req_valid = '1; ng = 0;
        for (int c = 0; c < 30 && ng < 5; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            for (int i = 0; i < NR; i++)
                if (hs[i] && ng < 5) begin gidx[ng] = i; gcyc[ng] = cyc; ng++; end
            @(posedge clk); #1;
            req_valid = (req_valid & ~hs) | rsp_valid;
        end
        req_valid = '0;
        repeat (4) @(posedge clk); #1;
        chk("cont_grants", ng, 5);
        for (int k = 0; k < ng; k++) chk("cont_order", gidx[k], exp_order[k]);
        for (int k = 0; k + 1 < ng; k++) chk("cont_spacing", gcyc[k+1] - gcyc[k], 3);

        // reset while a write is in ACCESS
        txn(2, 1'b1, 6, 32'hCAFE, rd, er);
        req_we[3] = 1'b1; req_addr[3] = 3'd1; req_wdata[3] = 32'h1234; req_valid[3] = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = req_ready[3]; end
        chk("mr_handshake", got, 1'b1);
        @(posedge clk); #1; req_valid = '0; rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mr_busy", busy, 1'b0);
            chk("mr_rsp_valid", rsp_valid, 4'b0);
            chk("mr_param_q", param_q, 256'h0);
        end
        @(posedge clk); #1; rst_n = 1'b1; req_valid = '1;
        @(negedge clk);
        chk("mr_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1; req_valid = '0;
        repeat (4) @(posedge clk); #1;

        // randomized traffic with lock toggling and one mid-run reset
        waiting = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            if (c == 701) rst_n = 1'b1;
            lock_i = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin waiting[i] = 1'b1; req_valid[i] = 1'b0; end
                else if (waiting[i] && rsp_valid[i]) waiting[i] = 1'b0;
                if (!waiting[i]) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            req_we[i] = 1'($urandom_range(0, 1));
                            req_addr[i] = AW'($urandom_range(0, NP - 1));
                            req_wdata[i] = $urandom;
                            req_valid[i] = 1'b1;
                        end
                    end else if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end
            end
            if (c == 700) begin rst_n = 1'b0; req_valid = '0; waiting = '0; end
        end
        req_valid = '0; lock_i = 1'b0;
        repeat (4) @(posedge clk); #1;

        // 6-entry instance: out-of-range indices
        txn6(0, 1'b0, 7, 32'h0, rd, er);
        chk("np6_rd7_err", er, 1'b1);
        chk("np6_rd7_data", rd, 32'h0);
        txn6(1, 1'b1, 6, 32'hAA, rd, er);
        chk("np6_wr6_err", er, 1'b1);
        chk("np6_wr6_bank", pq6, 192'h0);
        txn6(1, 1'b1, 5, 32'h77, rd, er);
        chk("np6_wr5_err", er, 1'b0);
        e6 = '0; e6[5*32 +: 32] = 32'h77;
        chk("np6_wr5_bank", pq6, e6);
        txn6(0, 1'b0, 5, 32'h0, rd, er);
        chk("np6_rd5_data", rd, 32'h77);
        txn6(0, 1'b0, 6, 32'h0, rd, er);
        chk("np6_rd6_err", er, 1'b1);
        chk("np6_rd6_data", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
